// File: rtl/inv_rotate_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : inv_rotate_pkg                                           |
// | Description : Shared encoder constants: rho offsets, FSM encoding and  |
// |               lane indexing, common to the forward and inverse rotate. |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
package inv_rotate_pkg;

    localparam int c_lanes  = 25;
    localparam int c_slices = 64;
    localparam int c_cnt_w  = 6;

    localparam logic [c_cnt_w-1:0] c_last_slice = 6'd63;

    // Indexed by lane i = 5*y + x.
    localparam logic [5:0] c_rho [c_lanes] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int lane_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_rotate_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : counter                                                  |
// | Description : Parameterised up-counter with enable, wraps at 2^WIDTH.  |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/inv_rotate_slice_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : slice_buffer                                             |
// | Description : Slice store with a single write port and a full-array    |
// |               read view; cleared to zero on reset.                     |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module slice_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 25,
    parameter int AW    = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [DEPTH-1:0][WIDTH-1:0] mem_view
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem <= '0;
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign mem_view = r_mem;

endmodule
`default_nettype wire

// File: rtl/inv_rotate.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : inv_rotate                                               |
// | Description : Inverse rho rotate: buffers a 64-slice frame, then       |
// |               streams decoded slices out under ready/valid control.    |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module inv_rotate
    import inv_rotate_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [24:0]   in_slice,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [24:0]   out_slice,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          done
);

    state_t                          r_state;
    logic                            r_out_valid;
    logic                            r_done;
    logic [c_cnt_w-1:0]              w_count;
    logic                            w_wr_en;
    logic                            w_rd_xfer;
    logic [c_slices-1:0][c_lanes-1:0] w_mem;
    logic [c_lanes-1:0]              w_decoded;

    // Gated by rst so in_ready is low during reset yet high in the very first
    // cycle after release, without waiting for a clock edge.
    assign in_ready  = rst & (r_state != ST_DRAIN);
    assign w_wr_en   = in_valid & in_ready;
    assign w_rd_xfer = r_out_valid & out_ready;

    // One counter serves both phases: it wraps 63->0 at the end of each.
    counter #(
        .WIDTH (c_cnt_w)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (w_wr_en | w_rd_xfer),
        .count (w_count)
    );

    slice_buffer #(
        .DEPTH (c_slices),
        .WIDTH (c_lanes),
        .AW    (c_cnt_w)
    ) u_slice_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_wr_en),
        .wr_addr  (w_count),
        .wr_data  (in_slice),
        .mem_view (w_mem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_wr_en && (w_count == c_last_slice)) begin
                        r_state     <= ST_DRAIN;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_xfer && (w_count == c_last_slice)) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Lane i of output slice z comes from stored slice (z + rho[i]) mod 64.
    for (genvar y = 0; y < 5; y++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_lane
            localparam int c_idx = lane_idx(x, y);
            logic [c_cnt_w-1:0] w_src;
            assign w_src            = w_count + c_rho[c_idx];
            assign w_decoded[c_idx] = w_mem[w_src][c_idx];
        end
    end

    assign out_valid = r_out_valid;
    assign out_slice = r_out_valid ? w_decoded : '0;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_inv_rotate.sv
`timescale 1ns/1ps
// Self-checking bench for inv_rotate: directed single-bit vectors, random
// frames against a modular-arithmetic reference, stalls, gaps and resets.
module tb_inv_rotate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [24:0] in_slice = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] out_slice;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        done;

    always #5 clk = ~clk;

    inv_rotate dut (
        .clk       (clk),
        .rst       (rst),
        .in_slice  (in_slice),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_slice (out_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int rho_tab [25] = '{
        0,  1,  62, 28, 27,
        36, 44, 6,  55, 20,
        3,  10, 43, 25, 39,
        41, 45, 15, 21, 8,
        18, 2,  61, 56, 14
    };

    logic [24:0] g_orig [64];
    logic [24:0] g_in   [64];
    logic [24:0] g_exp  [64];

    typedef struct {
        int lane;
        int in_z;
        int exp_z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: out[z] lane i = in[(z + rho_i) mod 64] lane i.
    task automatic model_inverse();
        for (int z = 0; z < 64; z++)
            for (int i = 0; i < 25; i++)
                g_exp[z][i] = g_in[(z + rho_tab[i]) % 64][i];
    endtask

    // Forward rotate of g_orig into g_in; decoding must recover g_orig.
    task automatic model_forward();
        for (int z = 0; z < 64; z++)
            for (int i = 0; i < 25; i++)
                g_in[z][i] = g_orig[(z - rho_tab[i] + 64) % 64][i];
    endtask

    task automatic load_frame(input int gap_pct, input bit in_done_cycle, input int stop_after = 64);
        int  idx   = 0;
        int  cyc   = 0;
        bit  first = 1'b1;
        while (idx < stop_after) begin
            if (!(first && in_done_cycle)) @(negedge clk);
            if (first && !in_done_cycle) chk("done_low_outside_pulse", {31'd0, done}, 32'd0);
            first = 1'b0;
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            chk("out_zero_load", {7'd0, out_slice}, 32'd0);
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_slice = in_valid ? g_in[idx] : 25'($urandom);
            if (in_valid) idx++;
            cyc++;
            if (cyc > 1000) begin
                chk("load_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic drain_frame(input int stall_pct, input int stop_after = 64);
        int          idx     = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        logic [24:0] held    = '0;
        while (idx < stop_after) begin
            @(negedge clk);
            if (cyc == 0) chk("first_valid_latency", {31'd0, out_valid}, 32'd1);
            chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
            chk("done_low_drain", {31'd0, done}, 32'd0);
            if (out_valid) begin
                chk($sformatf("slice_z%0d", idx), {7'd0, out_slice}, {7'd0, g_exp[idx]});
                if (stalled) chk("stall_stable", {7'd0, out_slice}, {7'd0, held});
                held      = out_slice;
                out_ready = ($urandom_range(0, 99) >= stall_pct);
                stalled   = !out_ready;
                if (out_ready) idx++;
            end else begin
                out_ready = 1'b0;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_slice = 25'($urandom);
            cyc++;
            if (cyc > 2000) begin
                chk("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
        chk("out_zero_idle", {7'd0, out_slice}, 32'd0);
        chk("in_ready_done_cycle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_slice", {7'd0, out_slice}, 32'd0);
        rst = 1'b1;
        #1;
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic random_orig();
        for (int z = 0; z < 64; z++) g_orig[z] = 25'($urandom);
    endtask

    initial begin
        vecs[0] = '{lane: 1,  in_z: 1,  exp_z: 0};
        vecs[1] = '{lane: 2,  in_z: 0,  exp_z: 2};
        vecs[2] = '{lane: 24, in_z: 14, exp_z: 0};
        vecs[3] = '{lane: 0,  in_z: 7,  exp_z: 7};
        vecs[4] = '{lane: 3,  in_z: 28, exp_z: 0};
        vecs[5] = '{lane: 12, in_z: 0,  exp_z: 21};
        vecs[6] = '{lane: 22, in_z: 63, exp_z: 2};
        vecs[7] = '{lane: 5,  in_z: 35, exp_z: 63};

        apply_reset(3);

        // All-zero frame, consumer always ready.
        for (int z = 0; z < 64; z++) begin
            g_in[z]  = '0;
            g_exp[z] = '0;
        end
        load_frame(0, 1'b0);
        drain_frame(0);
        check_done();

        // Single-bit vectors with hand-derived output positions.
        for (int v = 0; v < 8; v++) begin
            for (int z = 0; z < 64; z++) begin
                g_in[z]  = '0;
                g_exp[z] = '0;
            end
            g_in[vecs[v].in_z][vecs[v].lane]   = 1'b1;
            g_exp[vecs[v].exp_z][vecs[v].lane] = 1'b1;
            load_frame(0, 1'b0);
            drain_frame(0);
            check_done();
        end

        // Forward rotate then inverse must be the identity, with gaps/stalls.
        for (int f = 0; f < 3; f++) begin
            random_orig();
            model_forward();
            for (int z = 0; z < 64; z++) g_exp[z] = g_orig[z];
            load_frame(30, 1'b0);
            drain_frame(40);
            check_done();
        end

        // Back-to-back frames, the second starting in the done cycle.
        for (int z = 0; z < 64; z++) g_in[z] = 25'($urandom);
        model_inverse();
        load_frame(20, 1'b0);
        drain_frame(30);
        check_done();
        for (int z = 0; z < 64; z++) g_in[z] = 25'($urandom);
        model_inverse();
        load_frame(20, 1'b1);
        drain_frame(30);
        check_done();

        // Reset after 30 accepted slices, then a clean frame.
        for (int z = 0; z < 64; z++) g_in[z] = 25'($urandom);
        load_frame(20, 1'b0, 30);
        apply_reset(2);
        random_orig();
        model_forward();
        for (int z = 0; z < 64; z++) g_exp[z] = g_orig[z];
        load_frame(10, 1'b0);
        drain_frame(25);
        check_done();

        // Reset mid-drain leaves no residual output.
        for (int z = 0; z < 64; z++) g_in[z] = 25'($urandom);
        model_inverse();
        load_frame(0, 1'b0);
        drain_frame(20, 10);
        apply_reset(2);
        repeat (3) begin
            @(negedge clk);
            chk("no_output_after_reset", {31'd0, out_valid}, 32'd0);
            chk("no_slice_after_reset", {7'd0, out_slice}, 32'd0);
        end
        for (int z = 0; z < 64; z++) g_in[z] = 25'($urandom);
        model_inverse();
        load_frame(15, 1'b0);
        drain_frame(15);
        check_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
